// File: rtl/fib_seq_ctrl_if.sv
// Request/response bundle for the Fibonacci term sequencer.
// The master issues start/n; the slave returns status and result.
interface fib_seq_ctrl_if #(
  parameter int SIZE = 16,
  parameter int NW   = 6
);
  logic            start;
  logic [NW-1:0]   n;
  logic            ready;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] result;
  logic            overflow;
  logic [1:0]      mux_sel;

  modport master (
    output start, n,
    input  ready, busy, done, result, overflow, mux_sel
  );

  modport slave (
    input  start, n,
    output ready, busy, done, result, overflow, mux_sel
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Iterative Fibonacci sequencer: computes F(n) mod 2^SIZE
// with a four-state FSM and a sticky overflow flag.
module fib_seq_ctrl #(
  parameter int SIZE = 16,
  parameter int NW   = 6
) (
  input  logic         clk,
  input  logic         rst,
  fib_seq_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_ONE  = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic [1:0]      sel;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE-1:0] a_nx;
  logic [SIZE-1:0] res_q;
  logic [NW-1:0]   cnt;
  logic            sticky;
  logic            ovf_q;
  logic [SIZE:0]   sum;
  logic            last;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign last = (cnt == NW'(1));

  // A-source select follows the state directly
  always_comb begin
    sel = SEL_HOLD;
    unique case (state)
      INIT:    sel = SEL_ZERO;
      CALC:    sel = SEL_SUM;
      default: sel = SEL_HOLD;
    endcase
  end

  // A-source mux; the previous sum is already sitting in B
  always_comb begin
    a_nx = a;
    unique case (sel)
      SEL_ZERO: a_nx = '0;
      SEL_ONE:  a_nx = SIZE'(1);
      SEL_SUM:  a_nx = b;
      default:  a_nx = a;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = INIT;
      INIT: state_nx = (cnt != '0) ? CALC : DONE;
      CALC: if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      a     <= a_nx;
      unique case (state)
        IDLE: begin
          if (bus.start) cnt <= bus.n;
        end
        INIT: begin
          b      <= SIZE'(1);
          sticky <= 1'b0;
        end
        CALC: begin
          b   <= sum[SIZE-1:0];
          cnt <= cnt - NW'(1);
          // final step computes F(n+1); its carry is irrelevant
          if (sum[SIZE] && !last) sticky <= 1'b1;
        end
        default: begin
          res_q <= a;
          ovf_q <= sticky;
        end
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.busy     = (state == INIT) || (state == CALC);
  assign bus.done     = (state == DONE);
  assign bus.mux_sel  = sel;
  assign bus.result   = (state == DONE) ? a : res_q;
  assign bus.overflow = (state == DONE) ? sticky : ovf_q;

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 Parameter SIZE, default 16, is the datapath width of the result and the Fibonacci registers.
REQ-002 Parameter NW, default 6, is the width of the term-index input n.
REQ-003 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to compute F(n); sampled only when ready=1.
REQ-006 n  input  NW  index of the requested term, sampled with start.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 busy  output  1  high in INIT and CALC.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 result  output  SIZE  F(n) mod 2^SIZE, valid from the done cycle onward.
REQ-011 overflow  output  1  F(n) not representable in SIZE bits; valid with result.
REQ-012 mux_sel  output  2  select code driven to the 4:1 A-register source mux.
  - 00 = zero, 01 = one, 10 = A+B sum, 11 = hold.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, INIT, CALC, DONE.
REQ-014 IDLE with start=1 SHALL latch n into an NW-bit down-counter and go to INIT; start=0 stays in IDLE.
REQ-015 INIT SHALL load A<=0 and B<=1, then go to CALC if the counter is nonzero, otherwise to DONE.
REQ-016 Each CALC cycle SHALL do A<=B, B<=(A+B) truncated to SIZE bits, and decrement the counter.
  - CALC goes to DONE on the cycle the counter decrements to 0.
REQ-017 DONE SHALL last one cycle, drive done=1, copy A into result, and return to IDLE.
REQ-018 mux_sel SHALL be 11 in IDLE, 00 in INIT, 10 in CALC and 11 in DONE.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high in cycle k+2+n.
  - n=0 gives done in cycle k+2.
REQ-020 A carry-out of A+B on any CALC iteration except the final one SHALL set an internal sticky overflow bit.
  - A carry on the final iteration SHALL be ignored, because that iteration computes F(n+1).
REQ-021 The sticky overflow bit SHALL clear in INIT and SHALL be copied to overflow in DONE.
REQ-022 start asserted while not in IDLE SHALL be ignored; it is neither queued nor able to change n.
REQ-023 A start in the cycle after DONE SHALL be accepted normally, giving back-to-back operation.
REQ-024 result and overflow SHALL hold their values from DONE until the next DONE.
REQ-025 result SHALL equal the truncated F(n) even when overflow=1.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-CALC.
REQ-027 Reset values SHALL be: A=0, B=0, counter=0, result=0, overflow=0, done=0, busy=0, ready=1, mux_sel=11.
REQ-028 rst SHALL take priority over start in the same cycle, and an interrupted computation SHALL produce no done pulse.

Verification
REQ-029 Reset then start with n=10, SIZE=16 -> done exactly 12 cycles after the accept edge; result=55, overflow=0; mux_sel sequence 00, 10 x10, 11.
REQ-030 n=0 -> done at k+2, result=0, overflow=0; then n=1 -> result=1, overflow=0.
REQ-031 SIZE=16, n=24 -> result=46368, overflow=0; then n=25 -> result=9489 (75025 mod 65536), overflow=1.
REQ-032 Start with n=20, pulse start with n=3 during CALC -> second request ignored; result=6765; ready stays 0 until after done.
REQ-033 Start with n=30, assert rst on the 5th CALC cycle -> next cycle ready=1, result=0, overflow=0, no done pulse; then n=7 -> result=13.
REQ-034 Back-to-back: n=5 then start asserted in the cycle after done with n=6 -> results 5 then 8; second done 8 cycles after the second accept edge.
